// File: rtl/pwm_duty_ramp.sv
// Compare-value slew stage ahead of the pwm generator.
// A 3-wire serial port loads the target and step. The compare value moves toward the target only on period_start.
module pwm_duty_ramp #(
    parameter int                       COUNTER_WIDTH = 10,
    parameter int                       STEP_WIDTH    = 4,
    parameter logic [COUNTER_WIDTH-1:0] RESET_CMP     = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ser_clk_i,
    input  logic                     ser_data_i,
    input  logic                     ser_load_i,
    input  logic                     period_start_i,
    output logic [COUNTER_WIDTH-1:0] cmp_value_o,
    output logic                     busy_o,
    output logic                     frame_err_o
);
    localparam int FRAME = STEP_WIDTH + COUNTER_WIDTH;
    localparam int CNT_W = $clog2(FRAME + 2);

    typedef enum logic {IDLE, RAMP} state_t;

    logic [2:0]               clk_sync, load_sync;
    logic [1:0]               data_sync;
    logic                     shift_edge, load_edge;
    logic [FRAME-1:0]         shift, shift_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [COUNTER_WIDTH-1:0] target, cmp, cmp_nxt;
    logic [STEP_WIDTH-1:0]    step;
    logic [COUNTER_WIDTH:0]   step_ext, up_sum, dn_lim;
    logic                     frame_err;
    state_t                   state, state_nxt;

    // Index 1 is the synchronized level and index 2 is the edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '0;
            load_sync <= '0;
            data_sync <= '0;
        end else begin
            clk_sync  <= {clk_sync[1:0], ser_clk_i};
            load_sync <= {load_sync[1:0], ser_load_i};
            data_sync <= {data_sync[0], ser_data_i};
        end
    end

    assign shift_edge = clk_sync[1] & ~clk_sync[2];
    assign load_edge  = load_sync[1] & ~load_sync[2];

    // The shift is resolved before the commit check, so a bit landing with the load edge counts.
    always_comb begin
        shift_nxt = shift;
        cnt_nxt   = cnt;
        if (shift_edge) begin
            shift_nxt = {shift[FRAME-2:0], data_sync[1]};
            if (cnt != CNT_W'(FRAME + 1))
                cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift     <= '0;
            cnt       <= '0;
            target    <= RESET_CMP;
            step      <= '0;
            frame_err <= 1'b0;
        end else begin
            shift <= shift_nxt;
            if (load_edge) begin
                cnt <= '0;
                if (cnt_nxt == CNT_W'(FRAME)) begin
                    target    <= shift_nxt[COUNTER_WIDTH-1:0];
                    step      <= shift_nxt[FRAME-1:COUNTER_WIDTH];
                    frame_err <= 1'b0;
                end else begin
                    frame_err <= 1'b1;
                end
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end

    // Clamp tests are done one bit wider, so neither direction can wrap.
    assign step_ext = {{(COUNTER_WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    assign up_sum   = {1'b0, cmp} + step_ext;
    assign dn_lim   = {1'b0, target} + step_ext;

    always_comb begin
        cmp_nxt = cmp;
        if (period_start_i && cmp != target) begin
            if (step == '0)
                cmp_nxt = target;
            else if (cmp < target)
                cmp_nxt = (up_sum >= {1'b0, target}) ? target : up_sum[COUNTER_WIDTH-1:0];
            else
                cmp_nxt = (dn_lim >= {1'b0, cmp}) ? target : cmp - step_ext[COUNTER_WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (cmp != target)
            state_nxt = RAMP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp   <= RESET_CMP;
            state <= IDLE;
        end else begin
            cmp   <= cmp_nxt;
            state <= state_nxt;
        end
    end

    assign cmp_value_o = cmp;
    assign busy_o      = (state == RAMP);
    assign frame_err_o = frame_err;
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp. It covers reset, jump, ramps with clamping, frame errors,
// a commit coinciding with period_start, and reset during a ramp.
module tb_pwm_duty_ramp;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_clk_i = 1'b0, ser_data_i = 1'b0, ser_load_i = 1'b0;
    logic       period_start_i = 1'b0;
    logic [9:0] cmp_value_o;
    logic       busy_o, frame_err_o;
    int         n_cmp = 0, n_err = 0;
    int         expv, npulse;

    pwm_duty_ramp dut (
        .clk(clk), .rst_n(rst_n), .ser_clk_i(ser_clk_i), .ser_data_i(ser_data_i),
        .ser_load_i(ser_load_i), .period_start_i(period_start_i),
        .cmp_value_o(cmp_value_o), .busy_o(busy_o), .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input int nbits, input logic [15:0] word);
        for (int i = nbits - 1; i >= 0; i--) begin
            ser_data_i = word[i];
            cyc(3);
            ser_clk_i = 1'b1;
            cyc(4);
            ser_clk_i = 1'b0;
            cyc(3);
        end
    endtask

    task automatic commit();
        ser_load_i = 1'b1;
        cyc(4);
        ser_load_i = 1'b0;
        cyc(6);
    endtask

    task automatic frame(input logic [3:0] st, input logic [9:0] tg);
        send_bits(14, {2'b00, st, tg});
        commit();
    endtask

    // Returns at the negedge after the posedge that consumed the pulse.
    task automatic pulse();
        period_start_i = 1'b1;
        @(negedge clk);
        period_start_i = 1'b0;
    endtask

    initial begin
        // Reset held while the serial pins toggle.
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            ser_clk_i = ~ser_clk_i; ser_data_i = ~ser_data_i; ser_load_i = ~ser_load_i;
            cyc(2);
        end
        ser_clk_i = 1'b0; ser_data_i = 1'b0; ser_load_i = 1'b0;
        chk("rst_cmp", cmp_value_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        rst_n = 1'b1;
        cyc(20);
        pulse();
        chk("post_rst_cmp", cmp_value_o, 0);
        chk("post_rst_busy", busy_o, 0);

        // Jump with step 0.
        frame(4'd0, 10'h1FF);
        chk("jump_busy", busy_o, 1);
        chk("jump_ferr", frame_err_o, 0);
        period_start_i = 1'b1;
        chk("jump_pre", cmp_value_o, 0);
        @(negedge clk);
        period_start_i = 1'b0;
        chk("jump_cmp", cmp_value_o, 10'h1FF);
        cyc(2);
        chk("jump_idle", busy_o, 0);

        // Return to 0, then ramp up by 8 toward 20.
        frame(4'd0, 10'd0);
        pulse();
        chk("to0", cmp_value_o, 0);
        frame(4'd8, 10'd20);
        pulse(); chk("up1", cmp_value_o, 8);
        chk("up_busy", busy_o, 1);
        pulse(); chk("up2", cmp_value_o, 16);
        pulse(); chk("up3", cmp_value_o, 20);
        pulse(); chk("up4", cmp_value_o, 20);
        cyc(2);
        chk("up_idle", busy_o, 0);

        // Ramp down from 0x3FF by 15 to 0, then back up.
        frame(4'd0, 10'h3FF);
        pulse();
        chk("to3ff", cmp_value_o, 10'h3FF);
        frame(4'd15, 10'd0);
        expv = 1023; npulse = 0;
        while (expv != 0 && npulse < 80) begin
            pulse();
            npulse++;
            expv = (expv > 15) ? expv - 15 : 0;
            chk("down", cmp_value_o, expv);
        end
        chk("down_n", npulse, 69);
        chk("down_end", cmp_value_o, 0);
        frame(4'd15, 10'h3FF);
        expv = 0; npulse = 0;
        while (expv != 1023 && npulse < 80) begin
            pulse();
            npulse++;
            expv = (expv + 15 < 1023) ? expv + 15 : 1023;
            chk("rise", cmp_value_o, expv);
        end
        chk("rise_end", cmp_value_o, 10'h3FF);

        // Frame errors: 13 bits, then a good frame, then 15 bits.
        send_bits(13, 16'h0000);
        commit();
        chk("ferr13", frame_err_o, 1);
        pulse();
        chk("ferr13_cmp", cmp_value_o, 10'h3FF);
        frame(4'd0, 10'h055);
        chk("fgood", frame_err_o, 0);
        pulse();
        chk("fgood_cmp", cmp_value_o, 10'h055);
        send_bits(15, 16'h0123);
        commit();
        chk("ferr15", frame_err_o, 1);
        pulse();
        chk("ferr15_cmp", cmp_value_o, 10'h055);

        // Commit coinciding with period_start: the slew still uses the old target.
        frame(4'd0, 10'd0);
        pulse();
        chk("sim_pre", cmp_value_o, 0);
        send_bits(14, {6'd0, 10'd100});
        ser_load_i = 1'b1;
        cyc(2);
        period_start_i = 1'b1;
        @(negedge clk);
        period_start_i = 1'b0;
        chk("sim_hold", cmp_value_o, 0);
        cyc(2);
        ser_load_i = 1'b0;
        cyc(6);
        chk("sim_busy", busy_o, 1);
        pulse();
        chk("sim_next", cmp_value_o, 100);

        // Asynchronous reset in the middle of a ramp and a frame.
        frame(4'd1, 10'h3FF);
        pulse(); pulse();
        chk("mid_cmp", cmp_value_o, 102);
        send_bits(5, 16'h001F);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cmp", cmp_value_o, 0);
        chk("async_busy", busy_o, 0);
        chk("async_ferr", frame_err_o, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        frame(4'd0, 10'h0AA);
        chk("after_rst_ferr", frame_err_o, 0);
        pulse();
        chk("after_rst_cmp", cmp_value_o, 10'h0AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
